// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
//   Handshake and status bundle for sync_fifo_param.
//   master : producer/consumer side (drives wr_en, i_data, rd_en, clr_err)
//   slave  : FIFO side (drives o_data, o_valid, count, flags, error flags)
//   Signals:
//     wr_en, i_data    write request and data
//     rd_en            read request
//     o_data, o_valid  registered read data, one-cycle pop strobe
//     full, empty, almost_full, almost_empty, count  occupancy status
//     overflow, underflow, clr_err                   sticky error flags + clear
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] i_data;
    logic              rd_en;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output wr_en, i_data, rd_en, clr_err,
        input  o_data, o_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, i_data, rd_en, clr_err,
        output o_data, o_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO, DEPTH = 2**ADDR_W words of DATA_W bits, registered
//   read port, occupancy count and threshold flags.
//   Ports:
//     clk      clock, all state on posedge
//     reset_p  asynchronous active-high reset
//     bus      sync_fifo_param_if.slave (handshake, data, status, error flags)
//   Optional build macro: SYNC_FIFO_ERR_FLAGS_EN
//     defined   : sticky overflow/underflow flags, cleared by clr_err
//     undefined : overflow/underflow tied low, clr_err ignored
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input logic            clk,
    input logic            reset_p,
    sync_fifo_param_if.slave bus
);
    localparam int              DEPTH    = 2**ADDR_W;
    localparam int              STAGES   = 1;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] ONE_C    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] rd_q;
    logic [STAGES:0]   vld_pipe;
    logic              full_w, empty_w, wr_acc, rd_acc;

    // Flags decode the count register only, so they move on clock edges.
    assign full_w  = (count == DEPTH_C);
    assign empty_w = (count == '0);

    // Full blocks the write and empty blocks the read, so a simultaneous
    // request at either boundary degrades to the one legal operation.
    assign wr_acc = bus.wr_en && !full_w;
    assign rd_acc = bus.rd_en && !empty_w;

    assign vld_pipe[0] = rd_acc;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            rd_q               <= '0;
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                rd_q   <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; empty hides stale contents after reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.i_data;
    end

    assign bus.o_data       = rd_q;
    assign bus.o_valid      = vld_pipe[STAGES];
    assign bus.count        = count;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count >= AFULL_C);
    assign bus.almost_empty = (count <= AEMPTY_C);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // Set has priority over clear so a coincident error is never lost.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (bus.wr_en && full_w)  || (ovf_q && !bus.clr_err);
            unf_q <= (bus.rd_en && empty_w) || (unf_q && !bus.clr_err);
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = bus.clr_err;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
//   Directed bench for sync_fifo_param (DATA_W=8, ADDR_W=4, AFULL_TH=12,
//   AEMPTY_TH=4). Builds with or without SYNC_FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_param;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_p = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    sync_fifo_param_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic test_reset;
        idle(); bus.i_data = 8'h00;
        reset_p = 1'b1;
        tick(); tick();
        reset_p = 1'b0;
        tick();
        n_chk++; if (bus.count !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else n_pass++;
        n_chk++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else n_pass++;
        n_chk++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else n_pass++;
        n_chk++; if (bus.almost_full !== 1'b0) $display("FAIL reset_afull: got %b want 0", bus.almost_full); else n_pass++;
        n_chk++; if (bus.almost_empty !== 1'b1) $display("FAIL reset_aempty: got %b want 1", bus.almost_empty); else n_pass++;
        n_chk++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_valid); else n_pass++;
        n_chk++; if (bus.o_data !== 8'h00) $display("FAIL reset_odata: got %h want 00", bus.o_data); else n_pass++;
        n_chk++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL reset_err: got %b%b want 00", bus.overflow, bus.underflow); else n_pass++;
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            bus.wr_en = 1'b1; bus.i_data = 8'(i);
            tick();
            n_chk++; if (bus.count !== 5'(i)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i); else n_pass++;
            n_chk++; if (bus.almost_full !== (i >= 12)) $display("FAIL fill_afull[%0d]: got %b want %b", i, bus.almost_full, (i >= 12)); else n_pass++;
            n_chk++; if (bus.full !== (i == 16)) $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, (i == 16)); else n_pass++;
            n_chk++; if (bus.empty !== 1'b0) $display("FAIL fill_empty[%0d]: got %b want 0", i, bus.empty); else n_pass++;
        end
        bus.i_data = 8'h99;
        tick();
        idle();
        n_chk++; if (bus.count !== 5'd16) $display("FAIL fill_17th_count: got %0d want 16", bus.count); else n_pass++;
        n_chk++; if (bus.full !== 1'b1) $display("FAIL fill_17th_full: got %b want 1", bus.full); else n_pass++;
        n_chk++; if (bus.overflow !== ERR_EN) $display("FAIL fill_17th_ovf: got %b want %b", bus.overflow, ERR_EN); else n_pass++;
        bus.clr_err = 1'b1; tick(); idle();
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 16; i++) begin
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
            n_chk++; if (bus.o_valid !== 1'b1) $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.o_valid); else n_pass++;
            n_chk++; if (bus.o_data !== 8'(i)) $display("FAIL drain_data[%0d]: got %h want %h", i, bus.o_data, 8'(i)); else n_pass++;
            n_chk++; if (bus.count !== 5'(16 - i)) $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.count, 16 - i); else n_pass++;
            n_chk++; if (bus.almost_empty !== ((16 - i) <= 4)) $display("FAIL drain_aempty[%0d]: got %b want %b", i, bus.almost_empty, ((16 - i) <= 4)); else n_pass++;
            n_chk++; if (bus.empty !== (i == 16)) $display("FAIL drain_empty[%0d]: got %b want %b", i, bus.empty, (i == 16)); else n_pass++;
            tick();
            n_chk++; if (bus.o_valid !== 1'b0) $display("FAIL drain_pulse[%0d]: got %b want 0", i, bus.o_valid); else n_pass++;
            n_chk++; if (bus.o_data !== 8'(i)) $display("FAIL drain_hold[%0d]: got %h want %h", i, bus.o_data, 8'(i)); else n_pass++;
        end
        bus.rd_en = 1'b1;
        tick();
        idle();
        n_chk++; if (bus.o_valid !== 1'b0) $display("FAIL drain_extra_valid: got %b want 0", bus.o_valid); else n_pass++;
        n_chk++; if (bus.o_data !== 8'h10) $display("FAIL drain_extra_data: got %h want 10", bus.o_data); else n_pass++;
        n_chk++; if (bus.count !== 5'd0) $display("FAIL drain_extra_count: got %0d want 0", bus.count); else n_pass++;
        n_chk++; if (bus.underflow !== ERR_EN) $display("FAIL drain_extra_unf: got %b want %b", bus.underflow, ERR_EN); else n_pass++;
        bus.clr_err = 1'b1; tick(); idle();
    endtask

    // 8 writes, 16 paired write+read, 8 reads: 24 words, pointers wrap.
    task automatic test_wrap;
        for (int k = 0; k < 8; k++) begin
            bus.wr_en = 1'b1; bus.i_data = 8'(160 + k);
            tick();
            n_chk++; if (bus.count !== 5'(k + 1)) $display("FAIL wrap_a_count[%0d]: got %0d want %0d", k, bus.count, k + 1); else n_pass++;
        end
        for (int k = 8; k < 24; k++) begin
            bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.i_data = 8'(160 + k);
            tick();
            n_chk++; if (bus.o_valid !== 1'b1) $display("FAIL wrap_b_valid[%0d]: got %b want 1", k, bus.o_valid); else n_pass++;
            n_chk++; if (bus.o_data !== 8'(160 + k - 8)) $display("FAIL wrap_b_data[%0d]: got %h want %h", k, bus.o_data, 8'(160 + k - 8)); else n_pass++;
            n_chk++; if (bus.count !== 5'd8) $display("FAIL wrap_b_count[%0d]: got %0d want 8", k, bus.count); else n_pass++;
        end
        bus.wr_en = 1'b0;
        for (int j = 16; j < 24; j++) begin
            bus.rd_en = 1'b1;
            tick();
            n_chk++; if (bus.o_data !== 8'(160 + j)) $display("FAIL wrap_c_data[%0d]: got %h want %h", j, bus.o_data, 8'(160 + j)); else n_pass++;
            n_chk++; if (bus.count !== 5'(23 - j)) $display("FAIL wrap_c_count[%0d]: got %0d want %0d", j, bus.count, 23 - j); else n_pass++;
        end
        idle();
        n_chk++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", bus.empty); else n_pass++;
        n_chk++; if ({bus.full, bus.almost_full} !== 2'b00) $display("FAIL wrap_full_flags: got %b%b want 00", bus.full, bus.almost_full); else n_pass++;
        n_chk++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL wrap_err: got %b%b want 00", bus.overflow, bus.underflow); else n_pass++;
    endtask

    task automatic test_simul;
        // empty: write wins, no pop
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.i_data = 8'h55;
        tick(); idle();
        n_chk++; if (bus.count !== 5'd1) $display("FAIL simul0_count: got %0d want 1", bus.count); else n_pass++;
        n_chk++; if (bus.o_valid !== 1'b0) $display("FAIL simul0_valid: got %b want 0", bus.o_valid); else n_pass++;
        n_chk++; if (bus.o_data !== 8'hB7) $display("FAIL simul0_data: got %h want b7", bus.o_data); else n_pass++;
        n_chk++; if (bus.underflow !== ERR_EN) $display("FAIL simul0_unf: got %b want %b", bus.underflow, ERR_EN); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            bus.wr_en = 1'b1; bus.i_data = 8'(8'h56 + k); tick();
        end
        // count 5: paired op keeps count
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.i_data = 8'h5A;
        tick(); idle();
        n_chk++; if (bus.count !== 5'd5) $display("FAIL simul5_count: got %0d want 5", bus.count); else n_pass++;
        n_chk++; if (bus.o_valid !== 1'b1) $display("FAIL simul5_valid: got %b want 1", bus.o_valid); else n_pass++;
        n_chk++; if (bus.o_data !== 8'h55) $display("FAIL simul5_data: got %h want 55", bus.o_data); else n_pass++;
        for (int k = 0; k < 11; k++) begin
            bus.wr_en = 1'b1; bus.i_data = 8'(8'h5B + k); tick();
        end
        idle();
        n_chk++; if (bus.full !== 1'b1) $display("FAIL simul16_pre_full: got %b want 1", bus.full); else n_pass++;
        // full: read wins, write dropped
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.i_data = 8'hEE;
        tick(); idle();
        n_chk++; if (bus.count !== 5'd15) $display("FAIL simul16_count: got %0d want 15", bus.count); else n_pass++;
        n_chk++; if (bus.o_data !== 8'h56) $display("FAIL simul16_data: got %h want 56", bus.o_data); else n_pass++;
        n_chk++; if (bus.overflow !== ERR_EN) $display("FAIL simul16_ovf: got %b want %b", bus.overflow, ERR_EN); else n_pass++;
        for (int k = 0; k < 15; k++) begin
            bus.rd_en = 1'b1; tick();
            n_chk++; if (bus.o_data !== 8'(8'h57 + k)) $display("FAIL simul_drain[%0d]: got %h want %h", k, bus.o_data, 8'(8'h57 + k)); else n_pass++;
        end
        idle();
        n_chk++; if (bus.empty !== 1'b1) $display("FAIL simul_drain_empty: got %b want 1", bus.empty); else n_pass++;
        bus.clr_err = 1'b1; tick(); idle();
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 8; k++) begin
            bus.wr_en = 1'b1; bus.i_data = 8'(8'h30 + k); tick();
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b1;
        tick(); idle();
        n_chk++; if (bus.count !== 5'd7 || bus.o_valid !== 1'b1 || bus.o_data !== 8'h30)
            $display("FAIL arst_pre: got cnt=%0d v=%b d=%h want cnt=7 v=1 d=30", bus.count, bus.o_valid, bus.o_data); else n_pass++;
        #2 reset_p = 1'b1;
        #1;
        n_chk++; if (bus.count !== 5'd0) $display("FAIL arst_count: got %0d want 0", bus.count); else n_pass++;
        n_chk++; if (bus.o_valid !== 1'b0 || bus.o_data !== 8'h00) $display("FAIL arst_out: got v=%b d=%h want v=0 d=00", bus.o_valid, bus.o_data); else n_pass++;
        n_chk++; if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100)
            $display("FAIL arst_flags: got %b%b%b%b want 1100", bus.empty, bus.almost_empty, bus.full, bus.almost_full); else n_pass++;
        #1 reset_p = 1'b0;
        tick();
        bus.wr_en = 1'b1; bus.i_data = 8'h77; tick();
        bus.wr_en = 1'b0; bus.rd_en = 1'b1; tick(); idle();
        n_chk++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h77) $display("FAIL arst_after: got v=%b d=%h want v=1 d=77", bus.o_valid, bus.o_data); else n_pass++;
        n_chk++; if (bus.count !== 5'd0) $display("FAIL arst_after_count: got %0d want 0", bus.count); else n_pass++;
    endtask

    task automatic test_err_flags;
        reset_p = 1'b1; tick(); reset_p = 1'b0; tick();
        bus.rd_en = 1'b1; tick(); idle();
        n_chk++; if (bus.underflow !== ERR_EN || bus.overflow !== 1'b0) $display("FAIL err_unf: got o=%b u=%b want o=0 u=%b", bus.overflow, bus.underflow, ERR_EN); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            bus.wr_en = 1'b1; bus.i_data = 8'(k); tick();
        end
        tick(); idle();
        n_chk++; if (bus.overflow !== ERR_EN || bus.underflow !== ERR_EN) $display("FAIL err_ovf: got o=%b u=%b want o=%b u=%b", bus.overflow, bus.underflow, ERR_EN, ERR_EN); else n_pass++;
        bus.clr_err = 1'b1; tick(); idle();
        n_chk++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL err_clr: got %b%b want 00", bus.overflow, bus.underflow); else n_pass++;
        bus.clr_err = 1'b1; bus.wr_en = 1'b1; tick(); idle();
        n_chk++; if (bus.overflow !== ERR_EN || bus.underflow !== 1'b0) $display("FAIL err_set_wins: got o=%b u=%b want o=%b u=0", bus.overflow, bus.underflow, ERR_EN); else n_pass++;
        n_chk++; if (bus.count !== 5'd16) $display("FAIL err_count: got %0d want 16", bus.count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_async_reset();
        test_err_flags();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO with registered read port, occupancy count and threshold flags. It provides general-purpose buffering between producer and consumer logic in a single clock domain, such as UART byte queues and FND/LED display command queues. It replaces the fixed 8-bit by 1024-entry raw RAM block with a handshaked, full/empty-protected buffer of configurable width and depth.

## Interface
Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 4: address width; depth DEPTH = 2**ADDR_W entries.
- AFULL_TH, 12: almost_full asserts when count >= AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 4: almost_empty asserts when count <= AEMPTY_TH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_p  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request; data is i_data.
- i_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- o_data  out  DATA_W  registered read data.
- o_valid  out  1  high for exactly one cycle when o_data carries a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR_W+1  number of stored words, 0..DEPTH.
- overflow  out  1  sticky error flag; see Configuration.
- underflow  out  1  sticky error flag; see Configuration.
- clr_err  in  1  synchronous clear of overflow and underflow.

## Operation
- The write is accepted when wr_en && !full. The block stores i_data at wr_ptr, then wr_ptr increments.
- The read is accepted when rd_en && !empty. The block loads mem[rd_ptr] into o_data, then rd_ptr increments.
- Accept decisions use full and empty as they stand before the clock edge.
- Both accepted in the same cycle: count is unchanged and both pointers advance.
- Full with wr_en && rd_en: the read is accepted and the write is rejected. Count goes DEPTH -> DEPTH-1.
- Empty with wr_en && rd_en: the write is accepted and the read is rejected. Count goes 0 -> 1 and o_valid stays 0.
- Rejected requests have no effect on pointers, count, memory or o_data.
- Pointers are ADDR_W bits wide and wrap modulo DEPTH. There is no bypass path: a word becomes readable the cycle after it is written.
- o_data holds its last popped value until the next accepted read.
- Flags are pure decodes of the count register, so they change only at clock edges and never glitch on inputs.
- reset_p (asynchronous, any time, including mid-burst) applies these values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - o_data = 0, o_valid = 0.
  - empty = 1, full = 0, almost_full = 0.
  - almost_empty = 1.
  - overflow = 0, underflow = 0.
- Memory contents are not cleared by reset. Stale data is unreachable because empty = 1.

## Timing
- Write-to-read latency: a word written at edge N can be popped by rd_en at edge N+1 and appears on o_data after edge N+1.
- Read latency: 1 cycle. o_data and o_valid update on the same edge that accepts rd_en.
- count and all four flags reflect both accepted operations of edge N immediately after edge N.
- Sustained throughput is one write and one read per cycle when neither full nor empty.

## Configuration
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any edge with wr_en && !rd_en && full, or wr_en && rd_en && full.
  - underflow sets on any edge with rd_en && empty.
  - Both flags stay set until clr_err. If set and clear occur in the same cycle, set wins.
- Not defined: overflow and underflow are tied to 0, clr_err is ignored, and no error logic is synthesised. The port list is identical in both builds.

## Test plan
- Reset, then write 0x01..0x10 into the DEPTH=16 FIFO with one word per cycle. Required response:
  - full = 1 and count = 16 after the 16th edge.
  - almost_full first asserts after the 12th write.
  - A 17th write is rejected and count stays 16.
- Read out all 16 words. Required response:
  - o_data sequence is 0x01..0x10, each with a one-cycle o_valid.
  - empty = 1 after the last read, and almost_empty = 1 from count = 4 downward.
  - A further rd_en gives o_valid = 0 and o_data stays 0x10.
- Write 24 words and read 24 words interleaved with count kept at 1..8, so the pointers wrap. Required response: read order matches write order exactly and no flags are spuriously set.
- Simultaneous wr_en && rd_en in three states. Required response:
  - At count = 16: count becomes 15 and the written word is dropped.
  - At count = 0: count becomes 1 and o_valid = 0.
  - At count = 5: count stays 5.
- Assert reset_p asynchronously mid-clock with count = 7. Required response:
  - All outputs take their reset values immediately.
  - After release, a write followed by a read returns the newly written word.
- With SYNC_FIFO_ERR_FLAGS_EN defined, exercise the error flags. Required response:
  - Write when full sets overflow = 1.
  - Read when empty sets underflow = 1.
  - clr_err clears both on the next edge.
  - Overflow condition together with clr_err leaves overflow = 1.
  - Without the macro, both flags stay 0 throughout.
